// File: rtl/add_sub_display_pkg.sv
// Shared types and constants for the add/sub seven-segment display.
// Contents: converter FSM state enum, display digit type, and active-low segment codes.
// Provides seg_code(), which maps a display digit to its {g,f,e,d,c,b,a} pattern.
package add_sub_display_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  // Digit values 0-9 are plain BCD; two extra codes cover the sign and blank positions.
  typedef logic [3:0] digit_t;
  localparam digit_t DIG_MINUS = 4'd10;
  localparam digit_t DIG_BLANK = 4'd15;

  // Shift steps for a 9-bit magnitude.
  localparam int BCD_STEPS = 9;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_code(input digit_t d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0:      s = SEG_0;
      4'd1:      s = SEG_1;
      4'd2:      s = SEG_2;
      4'd3:      s = SEG_3;
      4'd4:      s = SEG_4;
      4'd5:      s = SEG_5;
      4'd6:      s = SEG_6;
      4'd7:      s = SEG_7;
      4'd8:      s = SEG_8;
      4'd9:      s = SEG_9;
      DIG_MINUS: s = SEG_MINUS;
      default:   s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/add_sub_seg_display_bin_to_bcd.sv
// Sequential double-dabble converter: 9-bit unsigned in, three BCD nibbles out.
// Ports: clk, reset, start (accepted only when idle), bin, busy, done (1-cycle, bcd valid), bcd.
// Timing: start edge -> 9 shift cycles -> 1 LOAD cycle with done high -> idle.
module bin_to_bcd
  import add_sub_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  state_t      state_q, state_d;
  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] adj;
  logic [3:0]  cnt_q;

  // Add 3 to every nibble >= 5 before the shift, so it carries correctly into the next decade.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = CONVERT;
      end
      CONVERT: begin
        if (cnt_q == 4'(BCD_STEPS - 1)) state_d = LOAD;
      end
      LOAD: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        CONVERT: begin
          bcd_q <= {adj[10:0], bin_q[8]};
          bin_q <= {bin_q[7:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/add_sub_seg_display.sv
// Shows a 9-bit two's-complement result as signed decimal on a 4-digit multiplexed display.
// Ports: clk, reset (async high), result[8:0]; anode[3:0] and segment[7:0] active-low; busy.
// A changed result is converted (busy 10 cycles), then latched whole into the display regs.
module add_sub_seg_display
  import add_sub_display_pkg::*;
#(
  parameter int RESULT_WIDTH  = 9,
  parameter int REFRESH_COUNT = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [RESULT_WIDTH-1:0] result,
  output logic [3:0]              anode,
  output logic [7:0]              segment,
  output logic                    busy
);

  localparam int CNT_W = $clog2(REFRESH_COUNT);

  logic [RESULT_WIDTH-1:0] shown_q;
  logic                    pending_q;
  logic                    start;
  logic [RESULT_WIDTH-1:0] magnitude;
  logic                    conv_done;
  logic [11:0]             bcd;
  digit_t                  digit_q [4];
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              sel_q;

  // Negation stays within 9 bits: -256 maps to 256 as an unsigned magnitude.
  assign magnitude = result[RESULT_WIDTH-1] ? (~result + RESULT_WIDTH'(1)) : result;
  assign start     = !busy && ((result != shown_q) || pending_q);

  bin_to_bcd u_bin_to_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (magnitude),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // shown_q is frozen for the whole conversion, so its sign bit still matches the BCD at done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown_q   <= '0;
      pending_q <= 1'b1;
    end else if (start) begin
      shown_q   <= result;
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= DIG_BLANK;
    end else if (conv_done) begin
      digit_q[0] <= bcd[3:0];
      digit_q[1] <= (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? DIG_BLANK : bcd[7:4];
      digit_q[2] <= (bcd[11:8] == 4'd0) ? DIG_BLANK : bcd[11:8];
      digit_q[3] <= shown_q[RESULT_WIDTH-1] ? DIG_MINUS : DIG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      anode   <= 4'b1111;
      segment <= 8'hFF;
    end else begin
      if (cnt_q == CNT_W'(REFRESH_COUNT - 1)) begin
        cnt_q <= '0;
        sel_q <= sel_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      anode   <= ~(4'b0001 << sel_q);
      segment <= {1'b1, seg_code(digit_q[sel_q])};
    end
  end

endmodule

// File: tb/tb_add_sub_seg_display.sv
// Randomized bench for add_sub_seg_display with a decimal reference model and scoreboard.
// The model predicts conversions from result-change timing; the monitor checks every lit digit.
// Also checks reset values, one-hot anode, dp off, and busy against the model each cycle.
module tb_add_sub_seg_display;

  localparam int RC = 4;
  typedef logic [3:0][6:0] disp_t;  // [0]=ones .. [3]=sign, active-low g..a

  localparam logic [6:0] T_BLANK = 7'b1111111;
  localparam logic [6:0] T_MINUS = 7'b0111111;
  localparam logic [6:0] T_DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] result = 9'd0;
  logic [3:0] anode;
  logic [7:0] segment;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_seg_display #(.RESULT_WIDTH(9), .REFRESH_COUNT(RC)) dut (
    .clk     (clk),
    .reset   (reset),
    .result  (result),
    .anode   (anode),
    .segment (segment),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic disp_t model_disp(input int v);
    disp_t d;
    int mag, h, t, o;
    mag  = (v < 0) ? -v : v;
    h    = mag / 100;
    t    = (mag / 10) % 10;
    o    = mag % 10;
    d[0] = T_DIG[o];
    d[1] = (h == 0 && t == 0) ? T_BLANK : T_DIG[t];
    d[2] = (h == 0) ? T_BLANK : T_DIG[h];
    d[3] = (v < 0) ? T_MINUS : T_BLANK;
    return d;
  endfunction

  // Reference model: a converter that, when idle, picks up any new value and stays busy 10 cycles.
  disp_t exp_q[$];
  int    m_count;
  int    m_shown;
  bit    m_pending;
  bit    saw_edge;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count   = 0;
      m_shown   = 0;
      m_pending = 1'b1;
      saw_edge  = 1'b0;
      exp_q.delete();
    end else begin
      saw_edge = 1'b1;
      if (m_count == 0) begin
        if ($signed(result) != m_shown || m_pending) begin
          m_shown   = $signed(result);
          m_pending = 1'b0;
          m_count   = 10;
          exp_q.push_back(model_disp(m_shown));
        end
      end else begin
        m_count--;
      end
    end
  end

  // Monitor: a busy falling edge means the display regs took a new value; it appears on the
  // registered segment output one cycle later.
  disp_t cur, nxt;
  bit    sw;
  bit    prev_busy;

  always @(negedge clk) begin
    int idx;
    if (reset) begin
      chk("reset_anode", anode, 4'hF);
      chk("reset_segment", segment, 8'hFF);
      chk("reset_busy", busy, 0);
      cur       = {4{T_BLANK}};
      sw        = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (sw) begin
        cur = nxt;
        sw  = 1'b0;
      end
      chk("busy_vs_model", busy, (m_count != 0) ? 1 : 0);
      if (saw_edge) begin
        chk("one_anode_low", $countones(~anode), 1);
        chk("dp_off", segment[7], 1);
        idx = -1;
        for (int i = 0; i < 4; i++) if (!anode[i]) idx = i;
        if (idx >= 0) chk($sformatf("segment_digit%0d", idx), segment, {1'b1, cur[idx]});
      end
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          nxt = exp_q.pop_front();
          sw  = 1'b1;
        end
      end
      prev_busy = busy;
    end
  end

  task automatic drive(input int v, input int cycles);
    result = 9'(v);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    drive(0, 30);
    drive(123, 30);
    drive(-256, 30);
    drive(-7, 30);
    // Change mid-conversion: both values show, in order.
    drive(45, 3);
    drive(200, 40);
    // Several changes during one conversion collapse to the latest.
    drive(10, 2);
    drive(20, 2);
    drive(30, 40);
    // Reset pulse mid-conversion of 255.
    drive(255, 4);
    #2 reset = 1'b1;
    #1;
    chk("reset_now_anode", anode, 4'hF);
    chk("reset_now_segment", segment, 8'hFF);
    chk("reset_now_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    drive(255, 30);
    for (int k = 0; k < 150; k++) begin
      v = $urandom_range(0, 511);
      if ($urandom_range(0, 3) == 0) v = result;
      drive((v > 255) ? v - 512 : v, $urandom_range(1, 24));
    end
    drive(-1, 40);
    chk("scoreboard_drained", exp_q.size() + (sw ? 1 : 0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
